// File: rtl/key_debouncer_n.sv
// rtl/key_debouncer_n.sv - multi-channel key synchroniser, stable-count debouncer and auto-repeat generator
module key_debouncer_n #(
    parameter int N_KEYS        = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = 50000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [N_KEYS-1:0] NORM = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_t;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] rise_now;
    logic [N_KEYS-1:0] fall_now;

    // Synchronisers hold the normalised value, so reset to 0 means "not pressed".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_in ^ NORM;
            sync2 <= sync1;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_filt
        logic [CNT_W-1:0] cnt;
        logic             lvl_q;
        logic             prs_q;
        logic             rel_q;
        logic             done;

        assign done        = (cnt == CNT_W'(STABLE_CYCLES - 1));
        assign rise_now[k] = (sync2[k] != lvl_q) && done && sync2[k];
        assign fall_now[k] = (sync2[k] != lvl_q) && done && !sync2[k];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt   <= '0;
                lvl_q <= 1'b0;
                prs_q <= 1'b0;
                rel_q <= 1'b0;
            end else begin
                prs_q <= rise_now[k];
                rel_q <= fall_now[k];
                if (sync2[k] == lvl_q) begin
                    cnt <= '0;
                end else if (done) begin
                    lvl_q <= sync2[k];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign key_level[k]   = lvl_q;
        assign key_press[k]   = prs_q;
        assign key_release[k] = rel_q;
    end

    if (REPEAT_EN != 0) begin : g_rpt
        for (genvar k = 0; k < N_KEYS; k++) begin : g_key
            rpt_state_t       state_q;
            rpt_state_t       state_d;
            logic [TMR_W-1:0] timer_q;
            logic [TMR_W-1:0] timer_d;
            logic             rep_q;
            logic             rep_d;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= IDLE;
                    timer_q <= '0;
                    rep_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    timer_q <= timer_d;
                    rep_q   <= rep_d;
                end
            end

            // Timer counts down to 0; the edge that sees 0 issues the pulse.
            always_comb begin
                state_d = state_q;
                timer_d = timer_q;
                rep_d   = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (rise_now[k]) begin
                            state_d = DELAY;
                            timer_d = TMR_W'(REPEAT_DELAY - 1);
                        end
                    end
                    DELAY, RPT: begin
                        if (fall_now[k]) begin
                            state_d = IDLE;
                            timer_d = '0;
                        end else if (timer_q == '0) begin
                            rep_d   = 1'b1;
                            state_d = RPT;
                            timer_d = TMR_W'(REPEAT_PERIOD - 1);
                        end else begin
                            timer_d = timer_q - TMR_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                endcase
            end

            assign key_repeat[k] = rep_q;
        end
    end else begin : g_no_rpt
        assign key_repeat = '0;
    end

endmodule
